// File: rtl/pe_ctrl_issuer_pkg.sv
// pe_ctrl_issuer_pkg: shared state and control-word types for the PE-column issuer
package pe_ctrl_issuer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} issuer_state_t;
  typedef struct packed {
    logic [5:0] guard_map;
    logic       bit_mode;
    logic       kernel_mode;
    logic       is_odd_row;
    logic       end_of_row;
  } pe_ctrl_word_t;
endpackage

// File: rtl/pe_ctrl_issuer_if.sv
// pe_ctrl_issuer_if: descriptor, mask and PE-column control bus of the issuer
interface pe_ctrl_issuer_if #(parameter int NUM_COL = 4, parameter int RW = 8, parameter int GW = 8) ();
  logic               cfg_valid;
  logic               cfg_ready;
  logic [RW-1:0]      cfg_rows;
  logic [GW-1:0]      cfg_groups;
  logic               cfg_kernel_mode;
  logic               cfg_bit_mode;
  logic               mask_valid;
  logic               mask_ready;
  logic [5:0]         mask_data;
  logic [NUM_COL-1:0] ctrl_valid;
  logic [NUM_COL-1:0] ctrl_ready;
  logic [NUM_COL-1:0] ctrl_finish;
  logic [5:0]         guard_map_o;
  logic               bit_mode_o;
  logic               kernel_mode_o;
  logic               is_odd_row_o;
  logic               end_of_row_o;
  logic               busy;
  logic               layer_done;
  logic               err_finish;
  modport master (
    input  cfg_valid, cfg_rows, cfg_groups, cfg_kernel_mode, cfg_bit_mode,
           mask_valid, mask_data, ctrl_ready, ctrl_finish,
    output cfg_ready, mask_ready, ctrl_valid, guard_map_o, bit_mode_o, kernel_mode_o,
           is_odd_row_o, end_of_row_o, busy, layer_done, err_finish
  );
  modport slave (
    output cfg_valid, cfg_rows, cfg_groups, cfg_kernel_mode, cfg_bit_mode,
           mask_valid, mask_data, ctrl_ready, ctrl_finish,
    input  cfg_ready, mask_ready, ctrl_valid, guard_map_o, bit_mode_o, kernel_mode_o,
           is_odd_row_o, end_of_row_o, busy, layer_done, err_finish
  );
endinterface

// File: rtl/pe_ctrl_issuer_outst_tracker.sv
// pe_outst_tracker: one outstanding-word bit per column, set on issue, cleared on finish
module pe_outst_tracker #(parameter int NUM_COL = 4) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_COL-1:0] set_col,
  input  logic [NUM_COL-1:0] finish,
  output logic [NUM_COL-1:0] outst,
  output logic               all_clear,
  output logic               err_finish
);
  assign all_clear = ~|outst;
  // finish retires a live word; a finish on an idle column only raises the sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      outst      <= '0;
      err_finish <= 1'b0;
    end else begin
      outst      <= (outst & ~finish) | set_col;
      err_finish <= err_finish | |(finish & ~outst);
    end
endmodule

// File: rtl/pe_ctrl_issuer.sv
// pe_ctrl_issuer: turns a layer descriptor and mask stream into per-column control words
module pe_ctrl_issuer
  import pe_ctrl_issuer_pkg::*;
#(
  parameter int NUM_COL = 4,
  parameter int RW      = 8,
  parameter int GW      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pe_ctrl_issuer_if.master bus
);
  localparam int TW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  issuer_state_t      state, state_nx;
  logic [RW-1:0]      rows, row;
  logic [GW-1:0]      groups, grp;
  logic [TW-1:0]      tgt;
  logic               km, bm, layer_done_q;
  pe_ctrl_word_t      word;
  logic [NUM_COL-1:0] outst, tgt_oh, set_col;
  logic               all_clear, cfg_acc, mask_acc, issue, last_grp, last_word;
  assign tgt_oh         = NUM_COL'(1) << tgt;
  assign cfg_acc        = bus.cfg_valid && state == S_IDLE;
  assign mask_acc       = bus.mask_valid && state == S_LOAD;
  assign bus.ctrl_valid = (state == S_ISSUE && !outst[tgt]) ? tgt_oh : '0;
  assign issue          = |(bus.ctrl_valid & bus.ctrl_ready);
  assign set_col        = issue ? tgt_oh : '0;
  assign last_grp       = grp == groups;
  assign last_word      = last_grp && row == rows;
  assign bus.cfg_ready  = state == S_IDLE;
  assign bus.mask_ready = state == S_LOAD;
  assign bus.busy       = state != S_IDLE;
  assign bus.layer_done = layer_done_q;
  assign bus.guard_map_o   = word.guard_map;
  assign bus.bit_mode_o    = word.bit_mode;
  assign bus.kernel_mode_o = word.kernel_mode;
  assign bus.is_odd_row_o  = word.is_odd_row;
  assign bus.end_of_row_o  = word.end_of_row;
  pe_outst_tracker #(.NUM_COL(NUM_COL)) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_col    (set_col),
    .finish     (bus.ctrl_finish),
    .outst      (outst),
    .all_clear  (all_clear),
    .err_finish (bus.err_finish)
  );
  // layer sequencing: load a mask, issue it once the target column is free, drain at the end
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (cfg_acc) state_nx = (bus.cfg_rows == '0 || bus.cfg_groups == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (mask_acc) state_nx = S_ISSUE;
      S_ISSUE: if (issue) state_nx = last_word ? S_DRAIN : S_LOAD;
      S_DRAIN: if (all_clear) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // state register and the one-cycle layer_done pulse that follows S_DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      layer_done_q <= 1'b0;
    end else begin
      state        <= state_nx;
      layer_done_q <= state == S_DONE;
    end
  // descriptor latch, word register and row/group/column counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rows   <= '0;
      groups <= '0;
      km     <= 1'b0;
      bm     <= 1'b0;
      row    <= '0;
      grp    <= '0;
      tgt    <= '0;
      word   <= '0;
    end else begin
      if (cfg_acc) begin
        rows   <= bus.cfg_rows;
        groups <= bus.cfg_groups;
        km     <= bus.cfg_kernel_mode;
        bm     <= bus.cfg_bit_mode;
        row    <= RW'(1);
        grp    <= GW'(1);
        tgt    <= '0;
      end
      if (mask_acc) word <= '{guard_map: bus.mask_data, bit_mode: bm, kernel_mode: km,
                              is_odd_row: row[0], end_of_row: last_grp};
      if (issue) begin
        tgt <= (tgt == TW'(NUM_COL - 1)) ? '0 : tgt + TW'(1);
        grp <= last_grp ? GW'(1) : grp + GW'(1);
        row <= last_grp ? row + RW'(1) : row;
      end
    end
endmodule
